// File: rtl/set_assoc_dcache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module set_assoc_dcache #(
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             din,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic [31:0]             dout,
  output logic                    is_hit,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [31:0]             mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_rdata,
  output logic [2:0]              state_dbg
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             writeback_count
`endif
);

  localparam int OB = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 32 - IB - OB - 2;
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int AW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LW = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_WAIT      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic          valid_q [NUM_SETS][NUM_WAYS];
  logic          dirty_q [NUM_SETS][NUM_WAYS];
  logic [TB-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [LW-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [AW-1:0] age_q   [NUM_SETS][NUM_WAYS];

  logic [29:0]   req_word;
  logic [31:0]   req_din;
  logic          req_write;
  logic          miss_flag;
  logic [AW-1:0] victim;

  logic [OW-1:0] req_off;
  logic [IB-1:0] req_idx;
  logic [TB-1:0] req_tag;

  assign req_off = OW'(req_word & 30'(LINE_WORDS - 1));
  assign req_idx = IB'(req_word >> OB);
  assign req_tag = TB'(req_word >> (OB + IB));
  assign state_dbg = state_q;

  logic          hit;
  logic [AW-1:0] hit_way;
  logic [LW-1:0] hit_line;
  logic [LW-1:0] store_line;
  logic [31:0]   hit_word;
  logic          found_free;
  logic [AW-1:0] victim_sel;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  always_comb begin
    hit_line   = data_q[req_idx][hit_way];
    store_line = hit_line;
    hit_word   = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (int'(req_off) == i) begin
        hit_word             = hit_line[32*i +: 32];
        store_line[32*i +: 32] = req_din;
      end
    end
  end

  // Victim: lowest-index invalid way first, otherwise the oldest way in the set.
  always_comb begin
    found_free = 1'b0;
    victim_sel = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_free && !valid_q[req_idx][w]) begin
        found_free = 1'b1;
        victim_sel = AW'(w);
      end
    end
    if (!found_free) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == AW'(NUM_WAYS - 1)) victim_sel = AW'(w);
      end
    end
  end

  // Handshakes: a core request transfers on a cycle with is_input_valid && is_ready;
  // a memory request transfers on mem_req_valid && mem_req_ready, and all mem_req_*
  // stay stable from the first valid cycle until that transfer.
  logic accept, lookup_hit, lookup_miss, wb_done, install;

  always_comb begin
    state_d         = state_q;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    accept          = 1'b0;
    lookup_hit      = 1'b0;
    lookup_miss     = 1'b0;
    wb_done         = 1'b0;
    install         = 1'b0;
    case (state_q)
      S_IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid && (mem_read || mem_write)) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          lookup_hit      = 1'b1;
          is_output_valid = 1'b1;
          is_hit          = !miss_flag;
          if (!req_write) dout = hit_word;
          state_d = S_IDLE;
        end else begin
          lookup_miss = 1'b1;
          if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
            state_d = S_WRITEBACK;
          else
            state_d = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[req_idx][victim], req_idx, {(OB + 2){1'b0}}};
        mem_req_wdata = data_q[req_idx][victim];
        if (mem_req_ready) begin
          wb_done = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, {(OB + 2){1'b0}}};
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          install = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_word  <= '0;
      req_din   <= '0;
      req_write <= 1'b0;
      miss_flag <= 1'b0;
      victim    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_word  <= addr[31:2];
        req_din   <= din;
        req_write <= mem_write;
        miss_flag <= 1'b0;
      end
      if (lookup_miss) begin
        miss_flag <= 1'b1;
        victim    <= victim_sel;
      end
      if (lookup_hit) begin
        miss_flag <= 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (age_q[req_idx][w] < age_q[req_idx][hit_way])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
        end
        age_q[req_idx][hit_way] <= '0;
        if (req_write) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[req_idx][victim] <= 1'b0;
      if (install) begin
        valid_q[req_idx][victim] <= 1'b1;
        dirty_q[req_idx][victim] <= 1'b0;
      end
    end
  end

  // A store miss merges its word on the hit that follows the install.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (install) begin
        tag_q[req_idx][victim]  <= req_tag;
        data_q[req_idx][victim] <= mem_resp_rdata;
      end
      if (lookup_hit && req_write) data_q[req_idx][hit_way] <= store_line;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
    end else begin
      if (lookup_hit && !miss_flag) hit_count <= hit_count + 32'd1;
      if (lookup_miss && !miss_flag) miss_count <= miss_count + 32'd1;
      if (wb_done) writeback_count <= writeback_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_dcache.sv
// Directed bench for set_assoc_dcache (16 sets, 2 ways, 4 words) with a recency-list cache
// model, a reactive backing memory and a per-cycle compare process.
`timescale 1ns/1ps
module tb_set_assoc_dcache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready, is_output_valid, is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [2:0]   state_dbg;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count, writeback_count;
`endif

  set_assoc_dcache #(.NUM_SETS(16), .NUM_WAYS(2), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .is_input_valid(is_input_valid), .addr(addr), .mem_read(mem_read), .mem_write(mem_write),
    .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout),
    .is_hit(is_hit), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .state_dbg(state_dbg)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // exp_req entries: {write, line addr, wdata}; exp_resp entries: {is_load, hit, dout}
  logic [160:0] exp_req_q[$];
  logic [33:0]  exp_resp_q[$];

  int           resp_seen = 0, resp_cycle = 0;
  logic [31:0]  last_dout = '0;
  logic         last_hit = 1'b0;
  int           wb_seen = 0, refill_seen = 0, req_cycles = 0, last_req_cycles = 0;
  logic [31:0]  last_wb_addr = '0, last_refill_addr = '0;
  logic [127:0] last_wb_data = '0;
  bit           refill_go = 1'b0;
  logic [31:0]  refill_addr = '0, resp_line_addr = '0;
  int           stall_cnt = 0, resp_cnt = 0;

  // ---------------- backing memory + cache model ----------------
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem_ovr.exists(wa)) return mem_ovr[wa];
    return 32'hA000_0000 + wa;
  endfunction

  bit          m_valid [16][2];
  bit          m_dirty [16][2];
  logic [23:0] m_tag   [16][2];
  logic [31:0] m_data  [16][2][4];
  int          m_rec   [16][2];   // recency list per set, index 0 = most recent
  bit          mdl_hit;

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_rec[s][w]   = w;
      end
    end
    exp_req_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < 2; i++) if (m_rec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
    m_rec[s][0] = w;
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d);
    logic [3:0]   s;
    logic [1:0]   off;
    logic [23:0]  tg;
    logic [31:0]  base;
    logic [127:0] line;
    int           hw;
    s = a[7:4]; off = a[3:2]; tg = a[31:8];
    hw = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    mdl_hit = (hw >= 0);
    if (!mdl_hit) begin
      for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) hw = w;
      if (hw < 0) hw = m_rec[s][1];
      if (m_valid[s][hw] && m_dirty[s][hw]) begin
        base = {m_tag[s][hw], s, 4'h0};
        for (int i = 0; i < 4; i++) begin
          line[32*i +: 32] = m_data[s][hw][i];
          mem_ovr[base + 32'(4*i)] = m_data[s][hw][i];
        end
        exp_req_q.push_back({1'b1, base, line});
      end
      base = {tg, s, 4'h0};
      exp_req_q.push_back({1'b0, base, 128'h0});
      m_valid[s][hw] = 1;
      m_dirty[s][hw] = 0;
      m_tag[s][hw]   = tg;
      for (int i = 0; i < 4; i++) m_data[s][hw][i] = mem_word(base + 32'(4*i));
    end
    touch(s, hw);
    if (wr) begin
      m_data[s][hw][off] = d;
      m_dirty[s][hw] = 1;
    end
    exp_resp_q.push_back({!wr, mdl_hit, m_data[s][hw][off]});
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          for (int i = 0; i < 4; i++) mem_resp_rdata[32*i +: 32] = mem_word(resp_line_addr + 32'(4*i));
        end
      end
      if (refill_go) begin
        refill_go = 1'b0;
        resp_cnt = 2;
        resp_line_addr = refill_addr;
      end
      if (stall_cnt > 0 && mem_req_valid && !mem_req_write) begin
        check("stall_is_ready", is_ready, 1'b0);
        stall_cnt--;
        mem_req_ready = 1'b0;
      end else begin
        mem_req_ready = (stall_cnt == 0);
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    logic [160:0] r;
    logic [33:0]  e;
    @(negedge clk);
    if (!reset) begin
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req actual=%0h required=none", mem_req_addr);
        end else begin
          r = exp_req_q[0];
          check("req_write", mem_req_write, r[160]);
          check("req_addr", mem_req_addr, r[159:128]);
          if (r[160]) check("req_wdata", mem_req_wdata, r[127:0]);
          req_cycles++;
          if (mem_req_ready) begin
            void'(exp_req_q.pop_front());
            last_req_cycles = req_cycles;
            req_cycles = 0;
            if (r[160]) begin
              wb_seen++;
              last_wb_addr = mem_req_addr;
              last_wb_data = mem_req_wdata;
            end else begin
              refill_seen++;
              last_refill_addr = mem_req_addr;
              refill_addr = r[159:128];
              refill_go = 1'b1;
            end
          end
        end
      end
      if (is_output_valid) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response actual=%0h required=none", dout);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_hit", is_hit, e[32]);
          if (e[33]) check("resp_dout", dout, e[31:0]);
          resp_seen++;
          resp_cycle = cyc;
          last_dout = dout;
          last_hit = is_hit;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    int n, t, dc;
    model_access(a, wr, d);
    t = 0;
    while (!is_ready && t < 100) begin @(posedge clk); #1; t++; end
    check("ready_before_drive", is_ready, 1'b1);
    n = resp_seen;
    is_input_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; din = d;
    dc = cyc;
    @(posedge clk); #1;
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    t = 0;
    while (resp_seen == n && t < 200) begin @(posedge clk); #1; t++; end
    if (resp_seen == n) begin
      checks++; errors++;
      $display("FAIL response_timeout addr=%0h actual=none required=pulse", a);
    end else if (mdl_hit) begin
      check("hit_latency", resp_cycle, dc + 1);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    is_input_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_ref, n_wb, t;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_is_ready", is_ready, 1'b1);
    check("rst_output_valid", is_output_valid, 1'b0);
    check("rst_is_hit", is_hit, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_write", mem_req_write, 1'b0);
    @(posedge clk); #1;

    // cold read, then hit on the same line
    access(32'h010, 1, 0, 0);
    check("t1_model_hit", mdl_hit, 1'b0);
    check("t1_hit", last_hit, 1'b0);
    check("t1_dout", last_dout, 32'hA000_0010);
    check("t1_refill_addr", last_refill_addr, 32'h010);
    n_ref = refill_seen;
    access(32'h014, 1, 0, 0);
    check("t1b_hit", last_hit, 1'b1);
    check("t1b_dout", last_dout, 32'hA000_0014);
    check("t1b_no_mem", refill_seen, n_ref);

    // store hit then load back
    access(32'h014, 0, 1, 32'hDEAD_BEEF);
    access(32'h014, 1, 0, 0);
    check("t2_hit", last_hit, 1'b1);
    check("t2_dout", last_dout, 32'hDEAD_BEEF);
    check("t2_no_mem", refill_seen, n_ref);

    // fill the set, force dirty eviction of line 0x010
    n_wb = wb_seen;
    access(32'h110, 1, 0, 0);
    access(32'h210, 1, 0, 0);
    check("t3_wb_count", wb_seen, n_wb + 1);
    check("t3_wb_addr", last_wb_addr, 32'h010);
    check("t3_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
    check("t3_refill_addr", last_refill_addr, 32'h210);
    access(32'h014, 1, 0, 0);
    check("t3_reread_hit", last_hit, 1'b0);
    check("t3_reread_dout", last_dout, 32'hDEAD_BEEF);

    // LRU with clean lines
    reset_dut();
    n_wb = wb_seen;
    access(32'h010, 1, 0, 0);
    access(32'h110, 1, 0, 0);
    access(32'h010, 1, 0, 0);
    check("t4_mru_hit", last_hit, 1'b1);
    access(32'h210, 1, 0, 0);
    check("t4_no_wb", wb_seen, n_wb);
    check("t4_refill_addr", last_refill_addr, 32'h210);
    access(32'h010, 1, 0, 0);
    check("t4_keep_hit", last_hit, 1'b1);
    access(32'h110, 1, 0, 0);
    check("t4_evicted_miss", last_hit, 1'b0);

    // store miss (write-allocate), read+write collision, then dirty eviction
    access(32'h044, 0, 1, 32'h1234_5678);
    check("wa_store_hit", last_hit, 1'b0);
    access(32'h044, 1, 0, 0);
    check("wa_load_dout", last_dout, 32'h1234_5678);
    check("wa_load_hit", last_hit, 1'b1);
    access(32'h048, 1, 1, 32'h55AA_55AA);
    access(32'h048, 1, 0, 0);
    check("rw_is_write", last_dout, 32'h55AA_55AA);
    access(32'h04C, 1, 0, 0);
    check("wa_other_word", last_dout, 32'hA000_004C);

    // valid with no op is ignored
    is_input_valid = 1'b1; addr = 32'h010; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    is_input_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("noop_ready", is_ready, 1'b1);

    access(32'h144, 1, 0, 0);
    access(32'h244, 1, 0, 0);
    check("wa_wb_addr", last_wb_addr, 32'h040);
    check("wa_wb_word2", last_wb_data[95:64], 32'h55AA_55AA);

    // refill request stalled by memory for 5 cycles
    stall_cnt = 5;
    access(32'h030, 1, 0, 0);
    check("t5_req_cycles", last_req_cycles, 6);
    check("t5_dout", last_dout, 32'hA000_0030);

    // reset while waiting for the refill response
    model_access(32'h050, 0, 0);
    n_ref = refill_seen;
    t = 0;
    while (!is_ready && t < 100) begin @(posedge clk); #1; t++; end
    is_input_valid = 1'b1; addr = 32'h050; mem_read = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    is_input_valid = 1'b0; mem_read = 1'b0;
    t = 0;
    while (refill_seen == n_ref && t < 100) begin @(posedge clk); #1; t++; end
    check("t6_refill_issued", refill_seen, n_ref + 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("t6_is_ready", is_ready, 1'b1);
    check("t6_mem_req_valid", mem_req_valid, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    access(32'h010, 1, 0, 0);
    check("t6_after_reset_miss", last_hit, 1'b0);
    access(32'h050, 1, 0, 0);
    check("t6_line_not_installed", last_hit, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_req_drained", exp_req_q.size(), 0);
    check("exp_resp_drained", exp_resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
